// File: rtl/intr_gen_pkg.sv
// Shared definitions for the interrupt pulse generator: channel FSM encoding,
// acknowledge-word stride and trigger mode constants.
package intr_gen_pkg;

    typedef enum logic [2:0] {
        StArmed  = 3'd0,
        StDelay  = 3'd1,
        StAssert = 3'd2,
        StRearm  = 3'd3,
        StDone   = 3'd4
    } ch_state_e;

    localparam int unsigned ACK_STRIDE = 4;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/intr_gen_channel.sv
// One interrupt channel: PC-triggered FSM with trigger delay and a fire budget.
// Configuration is captured only while reset is held low.
module intr_gen_channel
    import intr_gen_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned DLY_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_en,
    input  logic [29:0]      cfg_pc_word,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [29:0]      pc_word,
    input  logic             ack_hit,
    output logic             irq_next,
    output logic [CNT_W-1:0] fires_left
);

    ch_state_e        state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] fires_q, fires_d;
    logic [29:0]      pc_q;
    logic             mode_q;
    logic [DLY_W-1:0] delay_q;
    logic             pc_hit;
    logic             enter_assert;

    assign pc_hit     = (pc_word == pc_q);
    assign fires_left = fires_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= (cfg_en && (cfg_count != '0)) ? StArmed : StDone;
            fires_q <= cfg_count;
            dly_q   <= '0;
            pc_q    <= cfg_pc_word;
            mode_q  <= cfg_mode;
            delay_q <= cfg_delay;
        end else begin
            state_q <= state_d;
            fires_q <= fires_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        fires_d      = fires_q;
        enter_assert = 1'b0;
        unique case (state_q)
            StArmed: begin
                if (pc_hit) begin
                    if (delay_q == '0) begin
                        enter_assert = 1'b1;
                    end else begin
                        state_d = StDelay;
                        dly_d   = delay_q;
                    end
                end
            end
            StDelay: begin
                if (dly_q == DLY_W'(1)) begin
                    enter_assert = 1'b1;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            StAssert: begin
                // Ack wins over a simultaneous PC hit; re-trigger must pass through rearm.
                if ((mode_q == MODE_PULSE) || ack_hit) begin
                    state_d = (fires_q == '0) ? StDone : StRearm;
                end
            end
            StRearm: begin
                if (!pc_hit) begin
                    state_d = StArmed;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StDone;
            end
        endcase
        if (enter_assert) begin
            state_d = StAssert;
            fires_d = (fires_q == '0) ? '0 : fires_q - CNT_W'(1);
        end
    end

    // Masking with the level-mode ack lets the registered irq fall on the ack edge itself.
    always_comb begin
        irq_next = (state_q == StAssert) && !((mode_q == MODE_LEVEL) && ack_hit);
    end

endmodule

// File: rtl/intr_pulse_gen.sv
// Multi-channel interrupt stimulus source: acknowledge decode, registered
// interrupt OR and lowest-index priority encoder around NUM_CH channels.
module intr_pulse_gen
    import intr_gen_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned DLY_W    = 8,
    parameter logic [31:0] ACK_BASE = 32'h0000_7F20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             macroscopic_pc,
    input  logic [31:0]             m_data_addr,
    input  logic [3:0]              m_data_byteen,
    input  logic [NUM_CH-1:0]       cfg_en,
    input  logic [NUM_CH*32-1:0]    cfg_pc,
    input  logic [NUM_CH-1:0]       cfg_mode,
    input  logic [NUM_CH*CNT_W-1:0] cfg_count,
    input  logic [NUM_CH*DLY_W-1:0] cfg_delay,
    output logic [NUM_CH-1:0]       irq,
    output logic                    interrupt,
    output logic [2:0]              irq_id,
    output logic [NUM_CH*CNT_W-1:0] fires_left
);

    logic [NUM_CH-1:0] ack_hit;
    logic [NUM_CH-1:0] irq_next;
    logic [2:0]        id_next;
    logic              is_store;
    logic              unused_lo_bits;

    assign is_store       = |m_data_byteen;
    assign unused_lo_bits = ^{macroscopic_pc[1:0], m_data_addr[1:0]};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [31:0] AckAddr = ACK_BASE + 32'(ACK_STRIDE * k);
        logic unused_cfg_lo;

        assign unused_cfg_lo = ^cfg_pc[32*k +: 2];
        assign ack_hit[k]    = is_store && (m_data_addr[31:2] == AckAddr[31:2]);

        intr_gen_channel #(
            .CNT_W (CNT_W),
            .DLY_W (DLY_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_en      (cfg_en[k]),
            .cfg_pc_word (cfg_pc[32*k+2 +: 30]),
            .cfg_mode    (cfg_mode[k]),
            .cfg_count   (cfg_count[CNT_W*k +: CNT_W]),
            .cfg_delay   (cfg_delay[DLY_W*k +: DLY_W]),
            .pc_word     (macroscopic_pc[31:2]),
            .ack_hit     (ack_hit[k]),
            .irq_next    (irq_next[k]),
            .fires_left  (fires_left[CNT_W*k +: CNT_W])
        );
    end

    always_comb begin
        id_next = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (irq_next[k]) begin
                id_next = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq       <= '0;
            interrupt <= 1'b0;
            irq_id    <= '0;
        end else begin
            irq       <= irq_next;
            interrupt <= |irq_next;
            irq_id    <= id_next;
        end
    end

endmodule
